// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write data, per-register enables,
// read selects, save/restore requests and the sequencer handshake.
interface param_register_file_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_GP  = 4,
  parameter int NUM_SCR = 4
);
  localparam int SEL_W = $clog2(NUM_GP + NUM_SCR);

  logic [DATA_W-1:0]  I;
  logic [2:0]         FunSel;
  logic [NUM_GP-1:0]  RegSel;
  logic [NUM_SCR-1:0] ScrSel;
  logic [SEL_W-1:0]   OutASel;
  logic [SEL_W-1:0]   OutBSel;
  logic               Save;
  logic               Restore;
  logic [DATA_W-1:0]  OutA;
  logic [DATA_W-1:0]  OutB;
  logic               Busy;
  logic               Done;

  modport master (
    output I, FunSel, RegSel, ScrSel, OutASel, OutBSel, Save, Restore,
    input  OutA, OutB, Busy, Done
  );

  modport slave (
    input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel, Save, Restore,
    output OutA, OutB, Busy, Done
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register file: NUM_GP general-purpose and NUM_SCR scratch
// registers with per-register dec/inc/load/clear, two combinational read
// ports, and a save/restore sequencer copying R[i]<->S[i] one per cycle.
// Optional feature macro: RF_SATURATE_EN (unsigned saturating inc/dec;
// wrap-around when undefined).
module param_register_file #(
  parameter int DATA_W  = 16,
  parameter int NUM_GP  = 4,
  parameter int NUM_SCR = 4
) (
  input logic                  Clock,
  input logic                  Reset,
  param_register_file_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_GP + NUM_SCR);
  localparam int CNT_W = (NUM_GP > 1) ? $clog2(NUM_GP) : 1;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(NUM_GP - 1);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, done_nxt;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] r [NUM_GP];
  logic [DATA_W-1:0] s [NUM_SCR];

  function automatic logic [DATA_W-1:0] f_inc(input logic [DATA_W-1:0] v);
`ifdef RF_SATURATE_EN
    if (&v) return v;
`endif
    return v + ONE;
  endfunction

  function automatic logic [DATA_W-1:0] f_dec(input logic [DATA_W-1:0] v);
`ifdef RF_SATURATE_EN
    if (v == '0) return v;
`endif
    return v - ONE;
  endfunction

  function automatic logic [DATA_W-1:0] f_apply(input logic [2:0]        fs,
                                                input logic [DATA_W-1:0] v,
                                                input logic [DATA_W-1:0] din);
    case (fs)
      3'b000:  return f_dec(v);
      3'b001:  return f_inc(v);
      3'b010:  return din;
      3'b011:  return '0;
      default: return v;
    endcase
  endfunction

  // Sequencer state, copy counter and registered handshake outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state logic: Save has priority over Restore; last copy raises Done
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.Save) begin
          state_nxt = SAVE;
          busy_nxt  = 1'b1;
        end else if (bus.Restore) begin
          state_nxt = RESTORE;
          busy_nxt  = 1'b1;
        end
      end
      SAVE, RESTORE: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register array: FunSel ops only while idle, otherwise one copy per edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_GP; i++)  r[i] <= '0;
      for (int j = 0; j < NUM_SCR; j++) s[j] <= '0;
    end else if (state == IDLE) begin
      for (int i = 0; i < NUM_GP; i++)
        if (bus.RegSel[i]) r[i] <= f_apply(bus.FunSel, r[i], bus.I);
      for (int j = 0; j < NUM_SCR; j++)
        if (bus.ScrSel[j]) s[j] <= f_apply(bus.FunSel, s[j], bus.I);
    end else if (state == SAVE) begin
      s[cnt] <= r[cnt];
    end else begin
      r[cnt] <= s[cnt];
    end
  end

  // Read ports: R then S in select order; unmapped selects read zero
  always_comb begin
    bus.OutA = '0;
    bus.OutB = '0;
    for (int i = 0; i < NUM_GP; i++) begin
      if (bus.OutASel == SEL_W'(i)) bus.OutA = r[i];
      if (bus.OutBSel == SEL_W'(i)) bus.OutB = r[i];
    end
    for (int j = 0; j < NUM_SCR; j++) begin
      if (bus.OutASel == SEL_W'(NUM_GP + j)) bus.OutA = s[j];
      if (bus.OutBSel == SEL_W'(NUM_GP + j)) bus.OutB = s[j];
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default geometry (4 GP / 4 scratch)
// plus a 3 GP / 4 scratch instance for unmapped-select and scratch-beyond-GP cases.
module tb_param_register_file;
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  param_register_file_if #(.DATA_W(16), .NUM_GP(4), .NUM_SCR(4)) if0 ();
  param_register_file_if #(.DATA_W(16), .NUM_GP(3), .NUM_SCR(4)) if1 ();

  param_register_file #(.DATA_W(16), .NUM_GP(4), .NUM_SCR(4)) u0 (
    .Clock(Clock), .Reset(Reset), .bus(if0));
  param_register_file #(.DATA_W(16), .NUM_GP(3), .NUM_SCR(4)) u1 (
    .Clock(Clock), .Reset(Reset), .bus(if1));

`ifdef RF_SATURATE_EN
  localparam logic [15:0] INC_FFFF = 16'hFFFF;
  localparam logic [15:0] DEC_0000 = 16'h0000;
`else
  localparam logic [15:0] INC_FFFF = 16'h0000;
  localparam logic [15:0] DEC_0000 = 16'hFFFF;
`endif

  int passed = 0;
  int total  = 0;
  logic [15:0] pat [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rd0(input logic [2:0] sel, input logic [15:0] exp, input string tag);
    if0.OutASel = sel;
    #1;
    check(tag, if0.OutA, exp);
  endtask

  task automatic rd1(input logic [2:0] sel, input logic [15:0] exp, input string tag);
    if1.OutASel = sel;
    #1;
    check(tag, if1.OutA, exp);
  endtask

  // Checks n Busy cycles on u0 starting with the current one, ends in the Done cycle
  task automatic busy_run0(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      check({tag, "_busy"}, if0.Busy, 1'b1);
      check({tag, "_nodone"}, if0.Done, 1'b0);
      tick();
    end
    check({tag, "_busy_low"}, if0.Busy, 1'b0);
    check({tag, "_done"}, if0.Done, 1'b1);
  endtask

  initial begin
    pat[0] = 16'h0011; pat[1] = 16'h0022; pat[2] = 16'h0033; pat[3] = 16'h0044;
    Reset = 1'b1;
    if0.I = '0; if0.FunSel = 3'b100; if0.RegSel = '0; if0.ScrSel = '0;
    if0.OutASel = '0; if0.OutBSel = 3'd1; if0.Save = 1'b0; if0.Restore = 1'b0;
    if1.I = '0; if1.FunSel = 3'b100; if1.RegSel = '0; if1.ScrSel = '0;
    if1.OutASel = '0; if1.OutBSel = '0; if1.Save = 1'b0; if1.Restore = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    check("rst_outa", if0.OutA, 16'h0);
    check("rst_outb", if0.OutB, 16'h0);
    check("rst_busy", if0.Busy, 1'b0);
    check("rst_done", if0.Done, 1'b0);

    // Load R0, with latency check before the edge
    if0.FunSel = 3'b010; if0.I = 16'h1234; if0.RegSel = 4'b0001;
    #1;
    check("load_latency", if0.OutA, 16'h0);
    tick();
    if0.RegSel = '0; if0.FunSel = 3'b100;
    #1;
    check("load_r0", if0.OutA, 16'h1234);
    check("load_r1_untouched", if0.OutB, 16'h0);

    // Plain decrement, hold, clear on R0
    if0.RegSel = 4'b0001; if0.FunSel = 3'b000;
    tick();
    rd0(3'd0, 16'h1233, "dec_r0");
    if0.FunSel = 3'b111;
    tick();
    rd0(3'd0, 16'h1233, "hold_r0");
    if0.FunSel = 3'b001;
    tick();
    rd0(3'd0, 16'h1234, "inc_r0");
    if0.FunSel = 3'b011;
    tick();
    rd0(3'd0, 16'h0000, "clr_r0");

    // Wrap / saturate boundaries
    if0.RegSel = 4'b0010; if0.FunSel = 3'b010; if0.I = 16'hFFFF;
    tick();
    rd0(3'd1, 16'hFFFF, "load_r1_ffff");
    if0.FunSel = 3'b001;
    tick();
    rd0(3'd1, INC_FFFF, "inc_ffff");
    if0.RegSel = '0; if0.ScrSel = 4'b0001; if0.FunSel = 3'b000;
    tick();
    rd0(3'd4, DEC_0000, "dec_s0_zero");
    if0.ScrSel = '0;

    // R = {11,22,33,44}
    for (int i = 0; i < 4; i++) begin
      if0.RegSel = 4'(1 << i); if0.FunSel = 3'b010; if0.I = pat[i];
      tick();
    end
    if0.RegSel = '0; if0.FunSel = 3'b100;

    // Simultaneous Save+Restore: save wins; writes during Busy dropped
    if0.Save = 1'b1; if0.Restore = 1'b1;
    tick();
    if0.Save = 1'b0; if0.Restore = 1'b0;
    if0.RegSel = 4'hF; if0.ScrSel = 4'hF; if0.FunSel = 3'b011;
    busy_run0(4, "save");
    // Restore in Done cycle; clear of R at this edge precedes the restore
    if0.ScrSel = '0; if0.RegSel = 4'hF; if0.FunSel = 3'b011; if0.Restore = 1'b1;
    tick();
    if0.Restore = 1'b0; if0.RegSel = '0; if0.FunSel = 3'b100;
    rd0(3'd0, 16'h0, "req_cycle_clear");
    busy_run0(4, "restore");
    tick();
    check("done_one_cycle", if0.Done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd0(3'(i), pat[i], "restored_r");
      rd0(3'(4 + i), pat[i], "saved_s");
    end

    // Reset on the 2nd Busy cycle of a restore
    if0.Restore = 1'b1;
    tick();
    if0.Restore = 1'b0;
    check("mid_busy1", if0.Busy, 1'b1);
    tick();
    check("mid_busy2", if0.Busy, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("midrst_busy", if0.Busy, 1'b0);
    check("midrst_done", if0.Done, 1'b0);
    for (int k = 0; k < 8; k++) rd0(3'(k), 16'h0, "midrst_reg");
    for (int c = 0; c < 5; c++) begin
      tick();
      check("midrst_no_done", if0.Done, 1'b0);
    end

    // Both ports on select 5 -> S[1]
    if0.ScrSel = 4'b0010; if0.FunSel = 3'b010; if0.I = 16'hBEEF;
    if0.OutASel = 3'd5; if0.OutBSel = 3'd5;
    tick();
    if0.ScrSel = '0; if0.FunSel = 3'b100;
    #1;
    check("sel5_outa", if0.OutA, 16'hBEEF);
    check("sel5_outb", if0.OutB, 16'hBEEF);

    // 3 GP / 4 scratch instance
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    if1.ScrSel = 4'b1000; if1.FunSel = 3'b010; if1.I = 16'hABCD;
    tick();
    if1.ScrSel = '0; if1.RegSel = 3'b111; if1.I = 16'h0077;
    tick();
    if1.RegSel = '0; if1.FunSel = 3'b100;
    rd1(3'd7, 16'h0, "g3_sel7_zero");
    rd1(3'd6, 16'hABCD, "g3_s3");
    if1.Save = 1'b1;
    tick();
    if1.Save = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("g3_busy", if1.Busy, 1'b1);
      tick();
    end
    check("g3_done", if1.Done, 1'b1);
    check("g3_busy_low", if1.Busy, 1'b0);
    for (int k = 3; k < 6; k++) rd1(3'(k), 16'h0077, "g3_saved_s");
    rd1(3'd6, 16'hABCD, "g3_s3_untouched");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
